// File: rtl/timer_unit_if.sv
// CPU-side bus bundle for the timer unit: address/data/strobes toward the
// timer, read data, address-hit flag and the interrupt handshake back.
interface timer_unit_if;
   logic [15:0] address;
   logic [7:0]  data_in;
   logic        RE;
   logic        WE;
   logic [7:0]  data_out;
   logic        hit;
   logic        irq_timer;
   logic        irq_ack;

   modport master (
      output address, data_in, RE, WE, irq_ack,
      input  data_out, hit, irq_timer
   );

   modport slave (
      input  address, data_in, RE, WE, irq_ack,
      output data_out, hit, irq_timer
   );
endinterface

// File: rtl/timer_unit.sv
// Timer unit: free-running 16-bit divider (DIV), timer counter (TIMA) that
// counts falling edges of a selectable divider tap, modulo reload (TMA),
// control (TAC), and a sticky overflow interrupt. TIMA overflow goes through
// a one-cycle RELOAD state during which the CPU may cancel or redirect the
// reload.
module timer_unit #(
   parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
   input logic         clk,
   input logic         rst,
   timer_unit_if.slave bus
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_RELOAD = 1'b1
   } state_t;

   localparam logic [1:0] OFS_DIV  = 2'd0;
   localparam logic [1:0] OFS_TIMA = 2'd1;
   localparam logic [1:0] OFS_TMA  = 2'd2;
   localparam logic [1:0] OFS_TAC  = 2'd3;

   logic [15:0] r_div_cnt;
   logic [7:0]  r_tima;
   logic [7:0]  r_tma;
   logic [2:0]  r_tac;
   logic        r_tick_d;
   logic        r_irq;
   state_t      r_state;

   state_t      w_state_nxt;
   logic [7:0]  w_tima_nxt;
   logic        w_irq_set;
   logic [15:0] w_offset;
   logic        w_hit;
   logic [1:0]  w_sel;
   logic        w_wr;
   logic        w_wr_div;
   logic        w_wr_tima;
   logic        w_wr_tma;
   logic        w_wr_tac;
   logic        w_tap;
   logic        w_tick;
   logic        w_fall;
   logic [7:0]  w_rd_data;

   // Address decode: subtracting the base keeps the range test to one compare.
   assign w_offset  = bus.address - BASE_ADDR;
   assign w_hit     = (w_offset < 16'd4);
   assign w_sel     = w_offset[1:0];
   assign w_wr      = bus.WE & w_hit;
   assign w_wr_div  = w_wr & (w_sel == OFS_DIV);
   assign w_wr_tima = w_wr & (w_sel == OFS_TIMA);
   assign w_wr_tma  = w_wr & (w_sel == OFS_TMA);
   assign w_wr_tac  = w_wr & (w_sel == OFS_TAC);

   // Divider tap selected by TAC[1:0].
   always_comb begin
      w_tap = 1'b0;
      case (r_tac[1:0])
         2'b00:   w_tap = r_div_cnt[9];
         2'b01:   w_tap = r_div_cnt[3];
         2'b10:   w_tap = r_div_cnt[5];
         2'b11:   w_tap = r_div_cnt[7];
         default: w_tap = 1'b0;
      endcase
   end

   // A fall of the gated tap is an increment request, whatever caused it
   // (divider roll, DIV reset, tap change or timer disable).
   assign w_tick = r_tac[2] & w_tap;
   assign w_fall = r_tick_d & ~w_tick;

   // Reload state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, next TIMA value and interrupt-set request.
   always_comb begin
      w_state_nxt = r_state;
      w_tima_nxt  = r_tima;
      w_irq_set   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_wr_tima) begin
               // CPU write wins over a coincident increment
               w_tima_nxt = bus.data_in;
            end else if (w_fall) begin
               if (r_tima == 8'hFF) begin
                  w_tima_nxt  = 8'h00;
                  w_state_nxt = ST_RELOAD;
               end else begin
                  w_tima_nxt = r_tima + 8'd1;
               end
            end else begin
               w_tima_nxt = r_tima;
            end
         end
         ST_RELOAD: begin
            w_state_nxt = ST_RUN;
            if (w_wr_tima) begin
               // reload cancelled, no interrupt
               w_tima_nxt = bus.data_in;
            end else if (w_wr_tma) begin
               // the freshly written modulo is the one loaded
               w_tima_nxt = bus.data_in;
               w_irq_set  = 1'b1;
            end else begin
               w_tima_nxt = r_tma;
               w_irq_set  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_tima_nxt  = r_tima;
            w_irq_set   = 1'b0;
         end
      endcase
   end

   // Timer datapath registers and sticky interrupt (set beats ack).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= 16'h0000;
         r_tima    <= 8'h00;
         r_tma     <= 8'h00;
         r_tac     <= 3'b000;
         r_tick_d  <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         if (w_wr_div) begin
            r_div_cnt <= 16'h0000;
         end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
         end
         if (w_wr_tma) begin
            r_tma <= bus.data_in;
         end
         if (w_wr_tac) begin
            r_tac <= bus.data_in[2:0];
         end
         r_tick_d <= w_tick;
         r_tima   <= w_tima_nxt;
         if (w_irq_set) begin
            r_irq <= 1'b1;
         end else if (bus.irq_ack) begin
            r_irq <= 1'b0;
         end
      end
   end

   // Combinational read mux; idle bus reads as zero.
   always_comb begin
      w_rd_data = 8'h00;
      if (bus.RE && w_hit) begin
         case (w_sel)
            OFS_DIV:  w_rd_data = r_div_cnt[15:8];
            OFS_TIMA: w_rd_data = r_tima;
            OFS_TMA:  w_rd_data = r_tma;
            OFS_TAC:  w_rd_data = {5'b11111, r_tac};
            default:  w_rd_data = 8'h00;
         endcase
      end else begin
         w_rd_data = 8'h00;
      end
   end

   assign bus.data_out  = w_rd_data;
   assign bus.hit       = w_hit;
   assign bus.irq_timer = r_irq;

endmodule
